// File: rtl/mac_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_seq_ctrl_if                                                 |
// | Purpose  : Command, memory, MAC and result signals of mac_seq_ctrl.        |
// |            Names carry the direction seen by the sequencer (slave side).   |
// |            MAC_SEQ_STRIDE_EN adds the coefficient stride field.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface mac_seq_ctrl_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 6
);
  // Command from the decoder stage
  logic                  i_start;
  logic                  i_abort;
  logic [LEN_WIDTH-1:0]  i_length;
  logic [ADDR_WIDTH-1:0] i_base_a;
  logic [ADDR_WIDTH-1:0] i_base_b;
`ifdef MAC_SEQ_STRIDE_EN
  logic [ADDR_WIDTH-1:0] i_stride_b;
`endif
  // Memory and MAC side
  logic [ADDR_WIDTH-1:0] o_addr_a;
  logic [ADDR_WIDTH-1:0] o_addr_b;
  logic                  o_rd_en;
  logic [1:0]            o_mac_control;
  logic [DATA_WIDTH-1:0] i_acc_in;
  // Result handshake
  logic                  o_busy;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_result_valid;
  logic                  i_result_ready;

  modport slave (
`ifdef MAC_SEQ_STRIDE_EN
    input  i_stride_b,
`endif
    input  i_start, i_abort, i_length, i_base_a, i_base_b, i_acc_in, i_result_ready,
    output o_addr_a, o_addr_b, o_rd_en, o_mac_control, o_busy, o_result, o_result_valid
  );

  modport master (
`ifdef MAC_SEQ_STRIDE_EN
    output i_stride_b,
`endif
    output i_start, i_abort, i_length, i_base_a, i_base_b, i_acc_in, i_result_ready,
    input  o_addr_a, o_addr_b, o_rd_en, o_mac_control, o_busy, o_result, o_result_valid
  );
endinterface

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_seq_ctrl                                                    |
// | Purpose  : Sequencer for one length-N dot product on the MAC. Issues       |
// |            sample/coefficient addresses, drives the MAC control one cycle  |
// |            behind the reads, captures the accumulator and hands it off     |
// |            with valid/ready.                                               |
// |            Option: MAC_SEQ_STRIDE_EN enables a programmable coefficient    |
// |            stride (running adder); otherwise the stride is fixed at 1.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mac_seq_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 6
) (
  input wire logic      clock,
  input wire logic      resetn,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  localparam logic [1:0] c_op_hold  = 2'b00;
  localparam logic [1:0] c_op_load  = 2'b01;
  localparam logic [1:0] c_op_accum = 2'b10;
  localparam logic [1:0] c_op_clear = 2'b11;

  state_t                r_state, w_state_nx;
  logic [1:0]            r_ctrl, w_ctrl_nx;
  logic                  r_rd_en, w_rd_en_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_valid, w_valid_nx;
  logic [DATA_WIDTH-1:0] r_result, w_result_nx;
  logic [ADDR_WIDTH-1:0] r_addr_a, w_addr_a_nx;
  logic [ADDR_WIDTH-1:0] r_addr_b, w_addr_b_nx;
  logic [ADDR_WIDTH-1:0] r_stride, w_stride_nx;
  logic [LEN_WIDTH-1:0]  r_k, w_k_nx;
  logic [LEN_WIDTH-1:0]  r_len, w_len_nx;
  logic [ADDR_WIDTH-1:0] w_stride_in;

`ifdef MAC_SEQ_STRIDE_EN
  assign w_stride_in = bus.i_stride_b;
`else
  assign w_stride_in = ADDR_WIDTH'(1);
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Next state and next values of every registered output / counter
  always_comb begin
    w_state_nx  = r_state;
    w_ctrl_nx   = c_op_hold;
    w_rd_en_nx  = 1'b0;
    w_busy_nx   = r_busy;
    w_valid_nx  = r_valid;
    w_result_nx = r_result;
    w_addr_a_nx = r_addr_a;
    w_addr_b_nx = r_addr_b;
    w_stride_nx = r_stride;
    w_k_nx      = r_k;
    w_len_nx    = r_len;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_len_nx    = bus.i_length;
          w_stride_nx = w_stride_in;
          w_addr_a_nx = bus.i_base_a;
          w_addr_b_nx = bus.i_base_b;
          w_k_nx      = '0;
          w_busy_nx   = 1'b1;
          if (bus.i_length != '0) begin
            w_state_nx = S_ISSUE;
            w_rd_en_nx = 1'b1;
          end else begin
            // Empty product: clear the accumulator so the captured result is 0
            w_state_nx = S_DRAIN;
            w_ctrl_nx  = c_op_clear;
          end
        end
      end
      S_ISSUE: begin
        // Op is queued one cycle so it meets the read data of this term
        w_ctrl_nx = (r_k == '0) ? c_op_load : c_op_accum;
        if (r_k == r_len - LEN_WIDTH'(1)) begin
          w_state_nx = S_DRAIN;
        end else begin
          w_rd_en_nx  = 1'b1;
          w_k_nx      = r_k + LEN_WIDTH'(1);
          w_addr_a_nx = r_addr_a + ADDR_WIDTH'(1);
          w_addr_b_nx = r_addr_b + r_stride;
        end
      end
      S_DRAIN: begin
        w_state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_result_nx = bus.i_acc_in;
        w_valid_nx  = 1'b1;
        w_state_nx  = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.i_result_ready) begin
          w_valid_nx = 1'b0;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Abort wins over start and result_ready; the result register is left alone
    if (bus.i_abort && (r_state != S_IDLE)) begin
      w_state_nx  = S_IDLE;
      w_rd_en_nx  = 1'b0;
      w_busy_nx   = 1'b0;
      w_valid_nx  = 1'b0;
      w_result_nx = r_result;
      w_ctrl_nx   = (r_state == S_OUTPUT) ? c_op_hold : c_op_clear;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ctrl   <= c_op_hold;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_stride <= '0;
      r_k      <= '0;
      r_len    <= '0;
    end else begin
      r_ctrl   <= w_ctrl_nx;
      r_rd_en  <= w_rd_en_nx;
      r_busy   <= w_busy_nx;
      r_valid  <= w_valid_nx;
      r_result <= w_result_nx;
      r_addr_a <= w_addr_a_nx;
      r_addr_b <= w_addr_b_nx;
      r_stride <= w_stride_nx;
      r_k      <= w_k_nx;
      r_len    <= w_len_nx;
    end
  end

  assign bus.o_addr_a       = r_addr_a;
  assign bus.o_addr_b       = r_addr_b;
  assign bus.o_rd_en        = r_rd_en;
  assign bus.o_mac_control  = r_ctrl;
  assign bus.o_busy         = r_busy;
  assign bus.o_result       = r_result;
  assign bus.o_result_valid = r_valid;

endmodule

`default_nettype wire
